// File: rtl/traffic_ctrl_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : traffic_ctrl_multi_if
// Purpose  : Bundles the sensor/request inputs and lamp/status outputs of the
//            N-approach traffic-light controller into a single interface.
//            Optional flashing-yellow request exists only when the macro
//            TLC_FLASH_EN is defined.
// Ports    : tick_i       1-cycle time-base enable
//            demand_i     per-approach vehicle demand (level)
//            emerg_i      emergency preemption request (level)
//            emerg_way_i  approach to preempt to
//            hold_red_i   maintenance all-red request (level)
//            flash_i      flashing-yellow request (TLC_FLASH_EN only)
//            verde_o      green lamp per approach
//            amarillo_o   yellow lamp per approach
//            rojo_o       red lamp per approach
//            phase_o      approach owning right-of-way
//            state_o      encoded controller state
// Modports : master drives requests and observes lamps; slave is the controller.
// Rev      : 1.0  initial release
// ============================================================================
interface traffic_ctrl_multi_if #(
    parameter int N_WAYS = 2
);
    localparam int WAY_W = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;

    logic              tick_i;
    logic [N_WAYS-1:0] demand_i;
    logic              emerg_i;
    logic [WAY_W-1:0]  emerg_way_i;
    logic              hold_red_i;
`ifdef TLC_FLASH_EN
    logic              flash_i;
`endif
    logic [N_WAYS-1:0] verde_o;
    logic [N_WAYS-1:0] amarillo_o;
    logic [N_WAYS-1:0] rojo_o;
    logic [WAY_W-1:0]  phase_o;
    logic [2:0]        state_o;

    modport master (
`ifdef TLC_FLASH_EN
        output flash_i,
`endif
        output tick_i,
        output demand_i,
        output emerg_i,
        output emerg_way_i,
        output hold_red_i,
        input  verde_o,
        input  amarillo_o,
        input  rojo_o,
        input  phase_o,
        input  state_o
    );

    modport slave (
`ifdef TLC_FLASH_EN
        input  flash_i,
`endif
        input  tick_i,
        input  demand_i,
        input  emerg_i,
        input  emerg_way_i,
        input  hold_red_i,
        output verde_o,
        output amarillo_o,
        output rojo_o,
        output phase_o,
        output state_o
    );
endinterface
`default_nettype wire

// File: rtl/traffic_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : traffic_ctrl_multi
// Purpose  : Parametrised N-approach traffic-light controller. Timed green,
//            yellow and all-red phases advance on a tick enable; right-of-way
//            rotates round-robin among approaches with demand. Supports
//            emergency preemption to a chosen approach and a maintenance
//            all-red hold. Optional flashing-yellow mode is compiled in when
//            the macro TLC_FLASH_EN is defined.
// Ports    : clk    clock
//            reset  asynchronous, active-high
//            bus    traffic_ctrl_multi_if.slave (requests in, lamps out)
// States   : 0 GREEN, 1 YELLOW, 2 ALLRED, 3 PREEMPT, 4 HOLD, 5 FLASH
//            (5 only with TLC_FLASH_EN; otherwise any other code shows all red)
// Rev      : 1.0  initial release
// ============================================================================
module traffic_ctrl_multi #(
    parameter int N_WAYS    = 2,
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 32,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int CNT_W     = 6
) (
    input  logic                clk,
    input  logic                reset,
    traffic_ctrl_multi_if.slave bus
);

    localparam int WAY_W = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;

    localparam logic [CNT_W-1:0]  c_GREEN_MIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0]  c_GREEN_MAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0]  c_YELLOW_LAST    = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0]  c_ALLRED_LAST    = CNT_W'(ALLRED_T - 1);
    localparam logic [WAY_W-1:0]  c_LAST_WAY       = WAY_W'(N_WAYS - 1);
    localparam logic [WAY_W:0]    c_NUM_WAYS       = (WAY_W+1)'(N_WAYS);
    localparam logic [N_WAYS-1:0] c_WAY0           = N_WAYS'(1);

    typedef enum logic [2:0] {
        ST_GREEN   = 3'd0,
        ST_YELLOW  = 3'd1,
        ST_ALLRED  = 3'd2,
        ST_PREEMPT = 3'd3,
        ST_HOLD    = 3'd4
`ifdef TLC_FLASH_EN
        ,
        ST_FLASH   = 3'd5
`endif
    } state_t;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic [WAY_W-1:0] next_way(input logic [WAY_W-1:0] w);
        next_way = (w == c_LAST_WAY) ? '0 : w + WAY_W'(1);
    endfunction

    function automatic logic [N_WAYS-1:0] way_mask(input logic [WAY_W-1:0] w);
        way_mask = c_WAY0 << w;
    endfunction

    // First approach after w (wrapping) whose demand is set; if none of the
    // other approaches demand, fall back to the plain successor of w.
    function automatic logic [WAY_W-1:0] rr_next(input logic [WAY_W-1:0]  w,
                                                 input logic [N_WAYS-1:0] dem);
        logic [WAY_W-1:0] probe;
        logic             found;
        rr_next = next_way(w);
        probe   = w;
        found   = 1'b0;
        for (int k = 1; k < N_WAYS; k++) begin
            probe = next_way(probe);
            if (!found && ((dem & way_mask(probe)) != '0)) begin
                rr_next = probe;
                found   = 1'b1;
            end
        end
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [WAY_W-1:0]  cur_q, cur_d;
    logic [WAY_W-1:0]  tgt_q, tgt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pre_q, pre_d;
`ifdef TLC_FLASH_EN
    logic              blink_q, blink_d;
    logic              w_flash_req;
`endif
    logic [N_WAYS-1:0] verde_q, verde_d;
    logic [N_WAYS-1:0] amarillo_q, amarillo_d;
    logic [N_WAYS-1:0] rojo_q, rojo_d;

    logic              w_emerg_ok;
    logic [N_WAYS-1:0] w_cur_mask;
    logic              w_cur_dem;
    logic              w_other_dem;
    logic [WAY_W-1:0]  w_rr;
    logic [WAY_W-1:0]  w_tgt_upd;
    logic              w_pre_upd;
    logic [N_WAYS-1:0] w_lamp_mask;

    // Out-of-range emergency approach codes are treated as no request.
    assign w_emerg_ok  = bus.emerg_i && ({1'b0, bus.emerg_way_i} < c_NUM_WAYS);
    assign w_cur_mask  = way_mask(cur_q);
    assign w_cur_dem   = (bus.demand_i & w_cur_mask) != '0;
    assign w_other_dem = (bus.demand_i & ~w_cur_mask) != '0;
    assign w_rr        = rr_next(cur_q, bus.demand_i);
`ifdef TLC_FLASH_EN
    // hold_red outranks flash.
    assign w_flash_req = bus.flash_i && !bus.hold_red_i;
`endif

    // While clearing (yellow/all-red), a live emergency redirects the pending
    // approach; the clearance itself is never shortened.
    assign w_tgt_upd = (w_emerg_ok && !bus.hold_red_i) ? bus.emerg_way_i : tgt_q;
    assign w_pre_upd = (w_emerg_ok && !bus.hold_red_i) ? 1'b1 : pre_q;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
`ifdef TLC_FLASH_EN
        blink_d = blink_q;
`endif
        case (state_q)
            ST_GREEN: begin
                if (bus.hold_red_i) begin
                    state_d = ST_YELLOW;
                    tgt_d   = w_rr;
                    pre_d   = 1'b0;
                end
`ifdef TLC_FLASH_EN
                else if (w_flash_req) begin
                    state_d = ST_FLASH;
                end
`endif
                else if (w_emerg_ok && (bus.emerg_way_i == cur_q)) begin
                    state_d = ST_PREEMPT;
                end else if (w_emerg_ok) begin
                    // Emergency elsewhere: yield at once, ignoring GREEN_MIN.
                    state_d = ST_YELLOW;
                    tgt_d   = bus.emerg_way_i;
                    pre_d   = 1'b1;
                end else if (bus.tick_i) begin
                    if (w_other_dem &&
                        (((cnt_q >= c_GREEN_MIN_LAST) && !w_cur_dem) ||
                         (cnt_q == c_GREEN_MAX_LAST))) begin
                        state_d = ST_YELLOW;
                        tgt_d   = w_rr;
                        pre_d   = 1'b0;
                    end else if (cnt_q != c_GREEN_MAX_LAST) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_PREEMPT: begin
                cnt_d = '0;
                if (bus.hold_red_i) begin
                    state_d = ST_YELLOW;
                    tgt_d   = w_rr;
                    pre_d   = 1'b0;
                end
`ifdef TLC_FLASH_EN
                else if (w_flash_req) begin
                    state_d = ST_FLASH;
                end
`endif
                else if (!w_emerg_ok) begin
                    state_d = ST_YELLOW;
                    tgt_d   = w_rr;
                    pre_d   = 1'b0;
                end else if (bus.emerg_way_i != cur_q) begin
                    state_d = ST_YELLOW;
                    tgt_d   = bus.emerg_way_i;
                    pre_d   = 1'b1;
                end
            end

            ST_YELLOW: begin
`ifdef TLC_FLASH_EN
                if (w_flash_req) begin
                    state_d = ST_FLASH;
                end else
`endif
                begin
                    tgt_d = w_tgt_upd;
                    pre_d = w_pre_upd;
                    if (bus.tick_i) begin
                        if (cnt_q == c_YELLOW_LAST) begin
                            state_d = ST_ALLRED;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end

            ST_ALLRED: begin
`ifdef TLC_FLASH_EN
                if (w_flash_req) begin
                    state_d = ST_FLASH;
                end else
`endif
                begin
                    tgt_d = w_tgt_upd;
                    pre_d = w_pre_upd;
                    if (bus.tick_i) begin
                        if (cnt_q == c_ALLRED_LAST) begin
                            if (bus.hold_red_i) begin
                                state_d = ST_HOLD;
                            end else begin
                                state_d = ST_GREEN;
                                pre_d   = 1'b0;
                                // An empty intersection just steps to the next
                                // approach unless an emergency chose the target.
                                if (!w_pre_upd && (bus.demand_i == '0)) begin
                                    cur_d = next_way(cur_q);
                                    tgt_d = next_way(cur_q);
                                end else begin
                                    cur_d = w_tgt_upd;
                                end
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (!bus.hold_red_i) begin
                    state_d = ST_ALLRED;
                end
            end

`ifdef TLC_FLASH_EN
            ST_FLASH: begin
                if (!bus.flash_i || bus.hold_red_i) begin
                    state_d = ST_ALLRED;
                    tgt_d   = next_way(cur_q);
                    pre_d   = 1'b0;
                end else if (bus.tick_i) begin
                    blink_d = ~blink_q;
                end
            end
`endif

            default: begin
                // Unused encodings recover through a full clearance.
                state_d = ST_ALLRED;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
`ifdef TLC_FLASH_EN
        if ((state_d == ST_FLASH) && (state_q != ST_FLASH)) begin
            blink_d = 1'b1;
        end
`endif
    end

    // ------------------------------------------------------------------------
    // Lamp decode of the next state; registered so lamps track the state
    // register exactly with no combinational path to the drivers.
    // ------------------------------------------------------------------------
    assign w_lamp_mask = way_mask(cur_d);

    always_comb begin
        verde_d    = '0;
        amarillo_d = '0;
        rojo_d     = '1;
        case (state_d)
            ST_GREEN, ST_PREEMPT: begin
                verde_d = w_lamp_mask;
                rojo_d  = ~w_lamp_mask;
            end
            ST_YELLOW: begin
                amarillo_d = w_lamp_mask;
                rojo_d     = ~w_lamp_mask;
            end
`ifdef TLC_FLASH_EN
            ST_FLASH: begin
                rojo_d     = '0;
                amarillo_d = {N_WAYS{blink_d}};
            end
`endif
            default: begin
                rojo_d = '1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_GREEN;
            cur_q      <= '0;
            tgt_q      <= '0;
            cnt_q      <= '0;
            pre_q      <= 1'b0;
`ifdef TLC_FLASH_EN
            blink_q    <= 1'b1;
`endif
            verde_q    <= c_WAY0;
            amarillo_q <= '0;
            rojo_q     <= ~c_WAY0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            tgt_q      <= tgt_d;
            cnt_q      <= cnt_d;
            pre_q      <= pre_d;
`ifdef TLC_FLASH_EN
            blink_q    <= blink_d;
`endif
            verde_q    <= verde_d;
            amarillo_q <= amarillo_d;
            rojo_q     <= rojo_d;
        end
    end

    assign bus.verde_o    = verde_q;
    assign bus.amarillo_o = amarillo_q;
    assign bus.rojo_o     = rojo_q;
    assign bus.phase_o    = cur_q;
    assign bus.state_o    = state_q;

endmodule
`default_nettype wire
